// File: rtl/rd_resp_pkg.sv
// rd_resp_pkg: shared definitions for the read responder.
//   - default address/data widths
//   - FSM state encoding
package rd_resp_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      RESP  = 2'd2,
      DRAIN = 2'd3
   } state_e;

endpackage

// File: rtl/rd_resp_mem.sv
// rd_resp_mem: 2**ADDR_W x DATA_W storage, one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
//   clk      : write clock
//   we_i     : write enable (sampled at posedge clk)
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address (combinational read)
//   rdata_o  : read data
module rd_resp_mem #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rd_responder.sv
// rd_responder: answers two-cycle read requests from a local memory.
// A request is rd&&ce held for two consecutive edges at a stable address;
// the response (rvalid + rdata) is registered at the second edge. A request
// that drops early or changes address is flagged and dropped. Writes
// (wr&&ce&&!rd) preload the memory and are only accepted in IDLE.
//   clk, rst_n : clock, async active-low reset
//   ce         : chip enable
//   rd         : read request (held two cycles)
//   wr, wdata  : memory preload write
//   addr       : request / write address
//   rdata      : read data, zero unless rvalid
//   rvalid     : one-cycle completion pulse
//   busy       : FSM not in IDLE
//   err_short  : request dropped after one cycle
//   err_addr   : address changed during the hold
module rd_responder
   import rd_resp_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ce,
   input  logic              rd,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              busy,
   output logic              err_short,
   output logic              err_addr
);

   state_e            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] rdata_q;
   logic              rvalid_q;
   logic              busy_q;
   logic              err_short_q;
   logic              err_addr_q;

   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;

   // rd has priority over wr; writes outside IDLE are silently dropped.
   assign mem_we = (state_q == IDLE) && ce && wr && !rd;

   rd_resp_mem #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (addr),
      .wdata_i (wdata),
      .raddr_i (addr_q),
      .rdata_o (mem_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         rdata_q     <= '0;
         rvalid_q    <= 1'b0;
         busy_q      <= 1'b0;
         err_short_q <= 1'b0;
         err_addr_q  <= 1'b0;
      end else begin
         // Response and error flags are single-cycle pulses.
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         err_short_q <= 1'b0;
         err_addr_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (ce && rd) begin
                  addr_q  <= addr;
                  state_q <= HOLD;
                  busy_q  <= 1'b1;
               end
            end
            HOLD: begin
               if (!(ce && rd)) begin
                  err_short_q <= 1'b1;
                  state_q     <= IDLE;
                  busy_q      <= 1'b0;
               end else if (addr != addr_q) begin
                  err_addr_q <= 1'b1;
                  state_q    <= IDLE;
                  busy_q     <= 1'b0;
               end else begin
                  rvalid_q <= 1'b1;
                  rdata_q  <= mem_rdata;
                  state_q  <= RESP;
               end
            end
            RESP: begin
               // A rd held past two cycles parks in DRAIN so it is not
               // taken as a second request.
               if (rd) begin
                  state_q <= DRAIN;
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            DRAIN: begin
               if (!rd) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rdata     = rdata_q;
   assign rvalid    = rvalid_q;
   assign busy      = busy_q;
   assign err_short = err_short_q;
   assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_rd_responder.sv
// Bench for rd_responder: each issued request pushes its expected outcome
// (kind, data, cycle) into a queue; a monitor pops on every output pulse.
module tb_rd_responder;

   localparam int AW = 8;
   localparam int DW = 8;
   localparam int K_RV    = 1;
   localparam int K_SHORT = 2;
   localparam int K_ADDR  = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ce = 1'b0, rd = 1'b0, wr = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] wdata = '0;
   logic [DW-1:0] rdata;
   logic          rvalid, busy, err_short, err_addr;

   typedef struct {
      int            kind;
      logic [DW-1:0] data;
      int            cyc;
   } ev_t;

   ev_t           exp_q[$];
   logic [DW-1:0] mem_m [256];
   int            cyc = 0;
   int            total = 0;
   int            bad = 0;

   rd_responder #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ce        (ce),
      .rd        (rd),
      .wr        (wr),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .rvalid    (rvalid),
      .busy      (busy),
      .err_short (err_short),
      .err_addr  (err_addr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (cyc %0d)", nm, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Monitor: every output pulse must match the oldest expected event.
   always @(negedge clk) begin
      int  n;
      int  gk;
      ev_t e;
      if (rst_n) begin
         if (!rvalid) chk("rdata_idle_zero", rdata, 0);
         n = int'(rvalid) + int'(err_short) + int'(err_addr);
         if (n != 0) begin
            if (n > 1) gk = 9;
            else if (rvalid) gk = K_RV;
            else if (err_short) gk = K_SHORT;
            else gk = K_ADDR;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_pulse got kind=%0d exp none (cyc %0d)", gk, cyc);
            end else begin
               e = exp_q.pop_front();
               chk("event_kind", gk, e.kind);
               chk("event_cycle", cyc, e.cyc);
               if (e.kind == K_RV) chk("rdata", rdata, e.data);
            end
         end
      end
   end

   task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit en);
      ce = en; wr = 1'b1; rd = 1'b0; addr = a; wdata = d;
      tick();
      if (en) mem_m[a] = d;
      wr = 1'b0; ce = 1'b1;
      tick();
   endtask

   // Read transaction: rd for len cycles; a1/ce2 drive the second cycle.
   task automatic do_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input int len,
                        input bit ce2, input bit wrt, input logic [DW-1:0] wd);
      ev_t e;
      e.data = '0;
      if (len == 1 || !ce2) e.kind = K_SHORT;
      else if (a1 != a0) e.kind = K_ADDR;
      else begin
         e.kind = K_RV;
         e.data = mem_m[a0];
      end
      e.cyc = cyc + 2;
      exp_q.push_back(e);
      ce = 1'b1; rd = 1'b1; addr = a0; wr = wrt; wdata = wd;
      tick();
      chk("busy_hold", busy, 1);
      if (len >= 2) begin
         ce = ce2; addr = a1;
         tick();
         if (e.kind == K_RV) chk("busy_resp", busy, 1);
      end
      if (e.kind == K_RV) begin
         for (int i = 3; i <= len; i++) begin
            ce = 1'b1; addr = a0;
            tick();
            chk("busy_drain", busy, 1);
         end
      end
      rd = 1'b0; wr = 1'b0; ce = 1'b1;
      tick();
      chk("busy_idle", busy, 0);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_rdata"}, rdata, 0);
      chk({nm, "_rvalid"}, rvalid, 0);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_err_short"}, err_short, 0);
      chk({nm, "_err_addr"}, err_addr, 0);
   endtask

   initial begin
      logic [AW-1:0] a;
      int            op;
      #3;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1; ce = 1'b1;

      // Basic write then two-cycle read.
      do_wr(8'h3C, 8'hA5, 1'b1);
      do_rd(8'h3C, 8'h3C, 2, 1'b1, 1'b0, 8'h00);
      // Single-cycle request.
      do_rd(8'h10, 8'h10, 1, 1'b1, 1'b0, 8'h00);
      // Address change during hold.
      do_rd(8'h20, 8'h21, 2, 1'b1, 1'b0, 8'h00);
      // Long hold: one response only.
      do_rd(8'h3C, 8'h3C, 4, 1'b1, 1'b0, 8'h00);
      // ce dropping on the second cycle counts as short.
      do_rd(8'h3C, 8'h3C, 2, 1'b0, 1'b0, 8'h00);

      // Reset during HOLD.
      ce = 1'b1; rd = 1'b1; addr = 8'h3C;
      tick();
      chk("pre_reset_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("rst_hold");
      rd = 1'b0;
      tick();
      rst_n = 1'b1;
      tick(); tick();
      chk("post_rst_busy", busy, 0);

      // Reset during RESP: the pulse already seen, then cleared at once.
      do_rd_resp_reset();

      // wr with rd high is ignored.
      do_rd(8'h3C, 8'h3C, 2, 1'b1, 1'b1, 8'hFF);
      do_rd(8'h3C, 8'h3C, 2, 1'b1, 1'b0, 8'h00);
      // ce low: request and write ignored.
      ce = 1'b0; rd = 1'b1; addr = 8'h3C;
      tick(); tick();
      chk("ce_off_busy", busy, 0);
      rd = 1'b0; ce = 1'b1;
      tick();
      do_wr(8'h3C, 8'h11, 1'b0);
      do_rd(8'h3C, 8'h3C, 3, 1'b1, 1'b0, 8'h00);

      // Preload everything so random reads have a known model.
      for (int i = 0; i < 256; i++) do_wr(i[AW-1:0], DW'($urandom), 1'b1);

      for (int it = 0; it < 300; it++) begin
         op = $urandom_range(0, 6);
         a  = AW'($urandom);
         case (op)
            0: do_wr(a, DW'($urandom), 1'b1);
            1, 2: do_rd(a, a, $urandom_range(2, 4), 1'b1, 1'($urandom), DW'($urandom));
            3: do_rd(a, a, 1, 1'b1, 1'($urandom), DW'($urandom));
            4: do_rd(a, a ^ AW'(1 << $urandom_range(0, AW - 1)), 2, 1'b1, 1'b0, 8'h00);
            5: do_rd(a, a, 2, 1'b0, 1'($urandom), DW'($urandom));
            default: do_wr(a, DW'($urandom), 1'b0);
         endcase
      end

      repeat (4) tick();
      chk("pending_events", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   task automatic do_rd_resp_reset();
      ev_t e;
      e.kind = K_RV;
      e.data = mem_m[8'h3C];
      e.cyc  = cyc + 2;
      exp_q.push_back(e);
      ce = 1'b1; rd = 1'b1; addr = 8'h3C;
      tick(); tick();
      chk("resp_rvalid", rvalid, 1);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("rst_resp");
      rd = 1'b0;
      tick();
      rst_n = 1'b1;
      tick(); tick();
      chk("post_rst2_busy", busy, 0);
   endtask

endmodule
